// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle ARM core.
// Sequences each latched instruction through a Moore FSM, drives every
// datapath control input and holds the architectural NZCV flags.
// Optional feature macro: FPU_EN (adds the op=11 FPEXEC path).
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        FPUWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        LongFlag
);

    typedef enum logic [3:0] {
`ifdef FPU_EN
        S_FPEXEC = 4'd10,
`endif
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t      r_state;
    logic [3:0]  r_flags;

    logic [1:0]  w_op;
    logic        w_imm;
    logic [3:0]  w_cmd;
    logic        w_sbit;
    logic        w_rd_pc;
    logic        w_is_mul;
    logic        w_is_long;
    logic        w_is_cmp;
    logic        w_cond_ok;
    logic [1:0]  w_regsrc;
    logic [2:0]  w_alu_dp;
    logic        w_unused_bits;

    // ARM condition-code evaluation against a stored {N,Z,C,V}.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic ok;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: ok = z;
            4'b0001: ok = ~z;
            4'b0010: ok = c;
            4'b0011: ok = ~c;
            4'b0100: ok = n;
            4'b0101: ok = ~n;
            4'b0110: ok = v;
            4'b0111: ok = ~v;
            4'b1000: ok = c & ~z;
            4'b1001: ok = ~c | z;
            4'b1010: ok = (n == v);
            4'b1011: ok = (n != v);
            4'b1100: ok = ~z & (n == v);
            4'b1101: ok = z | (n != v);
            4'b1110: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_op      = Instr[27:26];
    assign w_imm     = Instr[25];
    assign w_cmd     = Instr[24:21];
    assign w_sbit    = Instr[20];
    assign w_rd_pc   = (Instr[15:12] == 4'hF);
    assign w_is_mul  = (Instr[27:24] == 4'b0000) && (Instr[7:4] == 4'b1001);
    assign w_is_long = w_is_mul & Instr[23];
    // CMP shares the SUB datapath but never writes a register.
    assign w_is_cmp  = ~w_is_mul && (w_cmd == 4'b1010);
    assign w_cond_ok = cond_check(Instr[31:28], r_flags);
    // Branches read PC as RA1; memory ops read Rd as RA2 (for stores).
    assign w_regsrc  = {(w_op == 2'b01), (w_op == 2'b10)};
    // Register-number fields consumed only by the datapath.
    assign w_unused_bits = &{Instr[19:16], Instr[11:8], Instr[3:0]};

    // Data-processing / multiply ALU operation decode.
    always_comb begin
        w_alu_dp = 3'b000;
        if (w_is_mul) begin
            if (Instr[23]) begin
                w_alu_dp = Instr[22] ? 3'b110 : 3'b101;
            end else begin
                w_alu_dp = 3'b100;
            end
        end else begin
            case (w_cmd)
                4'b0100: w_alu_dp = 3'b000;
                4'b0010: w_alu_dp = 3'b001;
                4'b1010: w_alu_dp = 3'b001;
                4'b0000: w_alu_dp = 3'b010;
                4'b1100: w_alu_dp = 3'b011;
                4'b0001: w_alu_dp = 3'b111;
                default: w_alu_dp = 3'b000;
            endcase
        end
    end

    // FSM state sequencing and NZCV flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_cond_ok) begin
                        r_state <= S_FETCH;
                    end else begin
                        case (w_op)
                            2'b00:   r_state <= w_imm ? S_EXECI : S_EXECR;
                            2'b01:   r_state <= S_MEMADR;
                            2'b10:   r_state <= S_BRANCH;
`ifdef FPU_EN
                            2'b11:   r_state <= S_FPEXEC;
`endif
                            default: r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: r_state <= Instr[20] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR, S_EXECI: begin
                    r_state <= S_ALUWB;
                    if (w_sbit) begin
                        // Multiplies only define N and Z; C and V are kept.
                        if (w_is_mul) begin
                            r_flags <= {ALUFlags[3:2], r_flags[1:0]};
                        end else begin
                            r_flags <= ALUFlags;
                        end
                    end else begin
                        r_flags <= r_flags;
                    end
                end
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode from state and Instr; reset shows FETCH selects with no writes.
    always_comb begin
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        FPUWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        LongFlag   = 1'b0;
        if (reset) begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
        end else begin
            case (r_state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    RegSrc    = w_regsrc;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_MEMADR: begin
                    RegSrc     = w_regsrc;
                    ALUSrcB    = 2'b01;
                    ImmSrc     = 2'b01;
                    ALUControl = Instr[23] ? 3'b000 : 3'b001;
                end
                S_MEMRD: begin
                    RegSrc = w_regsrc;
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    RegSrc    = w_regsrc;
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    PCWrite   = w_rd_pc;
                end
                S_MEMWR: begin
                    RegSrc   = w_regsrc;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUControl = w_alu_dp;
                end
                S_EXECI: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = w_alu_dp;
                end
                S_ALUWB: begin
                    RegWrite = ~w_is_cmp;
                    PCWrite  = ~w_is_cmp & w_rd_pc;
                    LongFlag = w_is_long;
                end
                S_BRANCH: begin
                    RegSrc    = 2'b01;
                    ALUSrcB   = 2'b01;
                    ImmSrc    = 2'b10;
                    ResultSrc = 2'b10;
                    PCWrite   = 1'b1;
                end
`ifdef FPU_EN
                S_FPEXEC: begin
                    FPUWrite   = 1'b1;
                    ALUControl = {1'b0, Instr[20], Instr[21]};
                end
`endif
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control
// vectors are queued when an instruction is issued and compared each cycle.
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, IRWrite, FPUWrite, MemWrite, AdrSrc, LongFlag;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [19:0] exp;
        logic [19:0] mask;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [19:0] M_EN    = 20'hF8001;
    localparam logic [19:0] M_ADR   = 20'h04000;
    localparam logic [19:0] M_RSRC0 = 20'h01000;
    localparam logic [19:0] M_ASA   = 20'h00C00;
    localparam logic [19:0] M_ASB   = 20'h00300;
    localparam logic [19:0] M_RS    = 20'h000C0;
    localparam logic [19:0] M_IMM   = 20'h00030;
    localparam logic [19:0] M_ALU   = 20'h0000E;

    logic [19:0] obs;
    assign obs = {PCWrite, RegWrite, IRWrite, FPUWrite, MemWrite, AdrSrc, RegSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, LongFlag};

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .FPUWrite(FPUWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .LongFlag(LongFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {PCWrite, RegWrite, IRWrite, FPUWrite, MemWrite}
    function automatic logic [19:0] v(input logic [4:0] en, input logic adr,
                                      input logic [1:0] rsrc, input logic [1:0] asa,
                                      input logic [1:0] asb, input logic [1:0] rs,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic lf);
        return {en, adr, rsrc, asa, asb, rs, imm, alu, lf};
    endfunction

    task automatic push(input string tag, input logic [19:0] e, input logic [19:0] m);
        exp_t x;
        x.tag = tag; x.exp = e; x.mask = m;
        sb_q.push_back(x);
    endtask

    task automatic e_fetch();
        push("FETCH", v(5'b10100, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0),
             M_EN | M_ADR | M_ASA | M_ASB | M_RS | M_ALU);
    endtask
    task automatic e_reset();
        push("RESET", v(5'b00000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0),
             M_EN | M_ADR | M_ASA | M_ASB | M_RS | M_ALU);
    endtask
    task automatic e_decode();
        push("DECODE", v(5'b00000, 1'b0, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 3'b000, 1'b0),
             M_EN | M_ASA | M_ASB | M_RS);
    endtask
    task automatic e_execr(input logic [2:0] alu);
        push("EXECR", v(5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, alu, 1'b0),
             M_EN | M_ASB | M_ALU);
    endtask
    task automatic e_execi(input logic [2:0] alu);
        push("EXECI", v(5'b00000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, alu, 1'b0),
             M_EN | M_ASB | M_IMM | M_ALU);
    endtask
    task automatic e_aluwb(input logic pcw, input logic rw, input logic lf);
        push("ALUWB", v({pcw, rw, 3'b000}, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, lf),
             M_EN | M_RS);
    endtask
    task automatic e_memadr(input logic [2:0] alu);
        push("MEMADR", v(5'b00000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, alu, 1'b0),
             M_EN | M_ASA | M_ASB | M_IMM | M_ALU);
    endtask
    task automatic e_memrd();
        push("MEMRD", v(5'b00000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0),
             M_EN | M_ADR | M_RS);
    endtask
    task automatic e_memwb(input logic pcw);
        push("MEMWB", v({pcw, 4'b1000}, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0),
             M_EN | M_RS);
    endtask
    task automatic e_memwr();
        push("MEMWR", v(5'b00001, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0),
             M_EN | M_ADR | M_RS);
    endtask
    task automatic e_branch();
        push("BRANCH", v(5'b10000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 3'b000, 1'b0),
             M_EN | M_RSRC0 | M_ASA | M_ASB | M_IMM | M_RS);
    endtask
    task automatic e_fpexec();
        push("FPEXEC", v(5'b00010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b011, 1'b0),
             M_EN | M_ALU);
    endtask

    // Pop one expectation per cycle and compare on the falling edge.
    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            assert ((obs & e.mask) === (e.exp & e.mask))
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h (Instr=%h)",
                       e.tag, obs & e.mask, e.exp & e.mask, Instr);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a data-processing/multiply instruction (4 cycles).
    task automatic dp(input logic [31:0] ins, input logic [3:0] fl, input logic imm,
                      input logic [2:0] alu, input logic pcw, input logic rw, input logic lf);
        Instr = ins; ALUFlags = fl;
        e_fetch(); e_decode();
        if (imm) e_execi(alu); else e_execr(alu);
        e_aluwb(pcw, rw, lf);
        drain(); step();
    endtask

    // Issue an instruction whose condition fails (2 cycles, no writes).
    task automatic skip(input logic [31:0] ins);
        Instr = ins; ALUFlags = 4'b1111;
        e_fetch(); e_decode();
        drain(); step();
    endtask

    initial begin
        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'b0000;
        repeat (2) @(posedge clk);
        e_reset(); drain();
        @(posedge clk); #1;
        reset = 1'b0;

        dp(32'hE0821003, 4'b1111, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); // ADD, S=0
        dp(32'hE0521003, 4'b0100, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0); // SUBS -> Z
        skip(32'h10821003);                                         // ADDNE fails
        dp(32'h00821003, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); // ADDEQ runs
        skip(32'h40821003);                                         // ADDMI fails
        skip(32'h20821003);                                         // ADDCS fails
        dp(32'hE0221003, 4'b1111, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0); // EOR
        dp(32'hE3821001, 4'b1111, 1'b1, 3'b011, 1'b0, 1'b1, 1'b0); // ORR imm
        dp(32'hE082F003, 4'b0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0); // ADD PC
        dp(32'hE3510005, 4'b0010, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0); // CMP #5 -> C
        skip(32'h00821003);                                         // ADDEQ fails
        dp(32'h20821003, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); // ADDCS runs

        // LDR R0,[R1,#4]: 5 cycles
        Instr = 32'hE5910004;
        e_fetch(); e_decode(); e_memadr(3'b000); e_memrd(); e_memwb(1'b0);
        drain(); step();
        // LDR PC,[R1,#4]
        Instr = 32'hE591F004;
        e_fetch(); e_decode(); e_memadr(3'b000); e_memrd(); e_memwb(1'b1);
        drain(); step();
        // STR R0,[R1,#-4]: 4 cycles
        Instr = 32'hE5010004;
        e_fetch(); e_decode(); e_memadr(3'b001); e_memwr();
        drain(); step();

        // UMULLS with ALU {N,C,V}: only N,Z load, so flags become 1010
        dp(32'hE0910392, 4'b1011, 1'b0, 3'b101, 1'b0, 1'b1, 1'b1);
        dp(32'h40821003, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); // ADDMI runs
        skip(32'h60821003);                                         // ADDVS fails
        dp(32'h20821003, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); // ADDCS runs
        dp(32'hE0C10392, 4'b0000, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1); // SMULL
        dp(32'hE0010392, 4'b0000, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0); // MUL

        // B: 3 cycles
        Instr = 32'hEA000000;
        e_fetch(); e_decode(); e_branch();
        drain(); step();

        // FP op
        Instr = 32'hEC300000;
        e_fetch(); e_decode();
`ifdef FPU_EN
        e_fpexec();
`endif
        drain(); step();

        // Reset asserted during MEMWB of an LDR
        Instr = 32'hE5910004;
        e_fetch(); e_decode(); e_memadr(3'b000); e_memrd();
        drain(); step();
        reset = 1'b1;
        e_reset(); drain();
        step();
        reset = 1'b0;
        skip(32'h40821003);                                         // ADDMI fails: N cleared
        skip(32'h20821003);                                         // ADDCS fails: C cleared
        dp(32'h10821003, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); // ADDNE runs
        e_fetch(); drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM core. It decodes the latched instruction and sequences each instruction through a Moore state machine. It drives every control input of the datapath (PC/IR/register/FPU write enables, source muxes, ALU/FPU operation, long-multiply select) and keeps the architectural NZCV flags register. It sits directly upstream of the datapath, consuming its `Instr` and `ALUFlags` outputs.

## Interface
Parameters: none.
- `clk` in 1: single core clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high; returns the FSM to FETCH and clears flags.
- `Instr` in 32: latched instruction from the datapath instruction register.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, combinational in the current cycle.
- `PCWrite`, `RegWrite`, `IRWrite`, `FPUWrite`, `MemWrite` out 1: write enables.
- `AdrSrc` out 1: 0 = PC, 1 = Result as memory address.
- `RegSrc` out 2: [0] forces RA1=15, [1] selects RA2=Instr[15:12].
- `ALUSrcA`, `ALUSrcB`, `ResultSrc`, `ImmSrc` out 2 each: datapath mux selects.
- `ALUControl` out 3: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UMULL, 110 SMULL, 111 EOR. For FP ops: [0] = mul/add, [1] = double/single.
- `LongFlag` out 1: regfile writes ALUOut2 to RdLo (Instr[15:12]) alongside RdHi.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FPEXEC.
- FETCH:
  - AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite=1, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=10, ResultSrc=10; RegSrc taken from the op.
  - Evaluates the condition field Instr[31:28] against the stored flags.
  - Condition false: go to FETCH.
  - Condition true, by op Instr[27:26]:
    - 00 with I=0: EXECR.
    - 00 with I=1: EXECI.
    - 01: MEMADR.
    - 10: BRANCH.
    - 11: FPEXEC.
- MEMADR:
  - ALUSrcA=00, ALUSrcB=01, ImmSrc=01; ALUControl = ADD if U=1, else SUB.
  - Next state: MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1; PCWrite=1 if Rd=15. Next state: FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state: FETCH.
- EXECR / EXECI: SrcB=00 / SrcB=01 (ImmSrc=00). Next state: ALUWB.
- ALUWB:
  - ResultSrc=00.
  - RegWrite=1 unless the op is CMP (cmd 1010).
  - PCWrite=1 if Rd=15.
  - LongFlag=1 for UMULL/SMULL.
  - Next state: FETCH.
- BRANCH:
  - RegSrc[0]=1, ALUSrcA=00, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1.
  - Next state: FETCH.
- FPEXEC: FPUWrite=1, RegWrite=0, ALUControl={0, Instr[20], Instr[21]}. Next state: FETCH.
- Multiply decode:
  - Applies when Instr[27:24]=0000 and Instr[7:4]=1001.
  - ALUControl: Instr[23]=0 gives MUL; otherwise Instr[22] selects SMULL (1) or UMULL (0).
- Flags register:
  - 4 bits, reset 0000.
  - Loaded from ALUFlags at the end of EXECR/EXECI when S (Instr[20])=1.
  - MUL/UMULL/SMULL update only N and Z.
- Write enables are 0 in every state not listed above.

## Timing
- Cycles per instruction:
  - Data-processing and multiply: 4.
  - LDR: 5.
  - STR: 4.
  - B: 3.
  - FP: 3.
  - Condition-failed: 2.
- While `reset`=1:
  - PCWrite, RegWrite, IRWrite, FPUWrite, MemWrite and LongFlag are forced to 0.
  - Mux selects show FETCH values.
  - The first cycle after deassertion is FETCH.
- Reset asserted mid-instruction aborts the instruction on that edge. No partial register write occurs after the reset edge.
- The condition check uses the flags stored before the current instruction. A flag update and a condition check never fall in the same cycle.
- All outputs are a function of state and Instr only (Moore), with no combinational path from ALUFlags to outputs.

## Configuration
- `FPU_EN` defined: the op=11 path and FPEXEC state are present.
- `FPU_EN` undefined:
  - op=11 is treated as undefined; DECODE returns to FETCH with no writes (2 cycles).
  - FPUWrite is tied to 0.
  - The FPEXEC state is absent.

## Test plan
- Reset, then `ADD R1,R2,R3` (0xE0821003): state sequence FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ALUControl=000; next state FETCH.
- `SUBS` with ALUFlags=0100, then `ADDNE` (cond 0001): ADDNE takes 2 cycles and RegWrite never asserts; flags read 0100.
- `LDR R0,[R1,#4]`: 5 cycles; MEMRD has AdrSrc=1; MEMWB has ResultSrc=01 and RegWrite=1. With Rd=15, PCWrite=1 in MEMWB.
- `UMULL` (Instr[23:22]=10, [7:4]=1001): ALUControl=101 in EXECR; LongFlag=1 with RegWrite=1 in ALUWB.
- FP op 0xEC300000: with `FPU_EN`, FPEXEC has FPUWrite=1, RegWrite=0, ALUControl=011. Without `FPU_EN`: 2 cycles, FPUWrite stays 0.
- Reset asserted in MEMWB: no RegWrite on that edge; next cycle is FETCH with flags 0000.
